// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_flex family: width helper,
// read-mode constants and error-flag bit positions.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bit positions of the sticky error flags inside a packed status word.
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;
  localparam int ERR_BITS          = 2;

  // Ceiling log2 for tools without $clog2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Handshake, data, threshold and status bundle of sync_fifo_flex.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = clog2(DEPTH + 1)
);

  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] input_data;
  logic             rd_en;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] af_thresh;
  logic [CNT_W-1:0] ae_thresh;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr_en, input_data, rd_en, af_thresh, ae_thresh,
    input  output_data, output_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, input_data, rd_en, af_thresh, ae_thresh,
    output output_data, output_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with a synchronous write port and an asynchronous
// read port. Kept separate so a vendor RAM macro can replace it.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one word per accepted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock circular FIFO with arbitrary depth, optional first-word
// fall-through, runtime almost-full/empty thresholds, synchronous flush
// and sticky overflow/underflow flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = FIFO_MODE_STD,
  parameter int PTR_W = clog2(DEPTH),
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  sync_fifo_flex_if.slave   fifo
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                vld_q, vld_d;
  logic [ERR_BITS-1:0] err_q, err_d;

  logic             full_s;
  logic             empty_s;
  logic             rd_acc;
  logic             wr_acc;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags depend only on the registered count.
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = fifo.rd_en && !empty_s;
  assign wr_acc = fifo.wr_en && (!full_s || fifo.rd_en);

  // Flush and reset both suppress the storage write on this edge.
  assign ram_we = wr_acc && !fifo.clear && reset_n;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (fifo.input_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Next-state: pointers, occupancy, registered read data and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    err_d    = err_q;
    if (fifo.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = ram_rdata;
        vld_d    = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (fifo.wr_en && full_s && !fifo.rd_en) begin
        err_d[ERR_OVERFLOW_BIT] = 1'b1;
      end
      if (fifo.rd_en && empty_s) begin
        err_d[ERR_UNDERFLOW_BIT] = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  // FWFT presents the head word directly; standard mode uses the read register.
  assign fifo.output_data  = (FWFT == FIFO_MODE_FWFT) ? ram_rdata : dout_q;
  assign fifo.output_valid = (FWFT == FIFO_MODE_FWFT) ? !empty_s  : vld_q;

  assign fifo.full         = full_s;
  assign fifo.empty        = empty_s;
  assign fifo.almost_full  = (count_q >= fifo.af_thresh);
  assign fifo.almost_empty = (count_q <= fifo.ae_thresh);
  assign fifo.count        = count_q;
  assign fifo.overflow     = err_q[ERR_OVERFLOW_BIT];
  assign fifo.underflow    = err_q[ERR_UNDERFLOW_BIT];

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three instances (depth 16 standard, depth 5
// standard, depth 16 FWFT) checked against a queue-based reference model.
module tb_sync_fifo_flex;

  logic clk;
  logic reset_n;

  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) if0 ();
  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(5))  if1 ();
  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) if2 ();

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut0 (.clk(clk), .reset_n(reset_n), .fifo(if0));
  sync_fifo_flex #(.WIDTH(8), .DEPTH(5),  .FWFT(0)) dut1 (.clk(clk), .reset_n(reset_n), .fifo(if1));
  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut2 (.clk(clk), .reset_n(reset_n), .fifo(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] mq2[$];
  bit         m_ovf[3];
  bit         m_unf[3];
  bit         m_vld[3];
  logic [7:0] m_dout[3];
  int         depth_c[3] = '{16, 5, 16};
  bit         fwft_c[3]  = '{1'b0, 1'b0, 1'b1};
  int         af_c[3]    = '{14, 4, 14};
  int         ae_c[3]    = '{2, 1, 2};

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_thresh();
    if0.af_thresh = 5'(af_c[0]); if0.ae_thresh = 5'(ae_c[0]);
    if1.af_thresh = 3'(af_c[1]); if1.ae_thresh = 3'(ae_c[1]);
    if2.af_thresh = 5'(af_c[2]); if2.ae_thresh = 5'(ae_c[2]);
  endtask

  task automatic set_inputs(input int k, input bit clr, input bit wr, input bit rd, input logic [7:0] d);
    if0.clear = (k == 0) && clr; if0.wr_en = (k == 0) && wr; if0.rd_en = (k == 0) && rd;
    if0.input_data = (k == 0) ? d : 8'h00;
    if1.clear = (k == 1) && clr; if1.wr_en = (k == 1) && wr; if1.rd_en = (k == 1) && rd;
    if1.input_data = (k == 1) ? d : 8'h00;
    if2.clear = (k == 2) && clr; if2.wr_en = (k == 2) && wr; if2.rd_en = (k == 2) && rd;
    if2.input_data = (k == 2) ? d : 8'h00;
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  function automatic logic [7:0] qhead(input int k);
    case (k)
      0:       return mq0[0];
      1:       return mq1[0];
      default: return mq2[0];
    endcase
  endfunction

  task automatic qclear(input int k);
    case (k)
      0:       mq0.delete();
      1:       mq1.delete();
      default: mq2.delete();
    endcase
  endtask

  task automatic qpush(input int k, input logic [7:0] d);
    case (k)
      0:       mq0.push_back(d);
      1:       mq1.push_back(d);
      default: mq2.push_back(d);
    endcase
  endtask

  task automatic qpop(input int k, output logic [7:0] d);
    case (k)
      0:       d = mq0.pop_front();
      1:       d = mq1.pop_front();
      default: d = mq2.pop_front();
    endcase
  endtask

  // Apply one clock edge of behaviour to instance j.
  task automatic model_one(input int j, input bit clr, input bit wr, input bit rd, input logic [7:0] d);
    int n;
    bit racc, wacc;
    logic [7:0] popped;
    n = qsize(j);
    if (clr) begin
      qclear(j);
      m_ovf[j] = 1'b0;
      m_unf[j] = 1'b0;
      m_vld[j] = 1'b0;
    end else begin
      racc = rd && (n != 0);
      wacc = wr && ((n != depth_c[j]) || rd);
      if (wr && (n == depth_c[j]) && !rd) m_ovf[j] = 1'b1;
      if (rd && (n == 0)) m_unf[j] = 1'b1;
      m_vld[j] = racc;
      if (racc) begin
        qpop(j, popped);
        m_dout[j] = popped;
      end
      if (wacc) qpush(j, d);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      qclear(j);
      m_ovf[j] = 1'b0; m_unf[j] = 1'b0; m_vld[j] = 1'b0; m_dout[j] = 8'h00;
    end
  endtask

  task automatic sample(input int k, output int cnt, output int f, output int e, output int af,
                        output int ae, output int ov, output int un, output int vld, output int dout);
    case (k)
      0: begin
        cnt = int'(if0.count); f = int'(if0.full); e = int'(if0.empty); af = int'(if0.almost_full);
        ae = int'(if0.almost_empty); ov = int'(if0.overflow); un = int'(if0.underflow);
        vld = int'(if0.output_valid); dout = int'(if0.output_data);
      end
      1: begin
        cnt = int'(if1.count); f = int'(if1.full); e = int'(if1.empty); af = int'(if1.almost_full);
        ae = int'(if1.almost_empty); ov = int'(if1.overflow); un = int'(if1.underflow);
        vld = int'(if1.output_valid); dout = int'(if1.output_data);
      end
      default: begin
        cnt = int'(if2.count); f = int'(if2.full); e = int'(if2.empty); af = int'(if2.almost_full);
        ae = int'(if2.almost_empty); ov = int'(if2.overflow); un = int'(if2.underflow);
        vld = int'(if2.output_valid); dout = int'(if2.output_data);
      end
    endcase
  endtask

  task automatic check_one(input string tag, input int k);
    int cnt, f, e, af, ae, ov, un, vld, dout, n;
    sample(k, cnt, f, e, af, ae, ov, un, vld, dout);
    n = qsize(k);
    chk($sformatf("%s.u%0d.count", tag, k), cnt, n);
    chk($sformatf("%s.u%0d.full", tag, k), f, int'(n == depth_c[k]));
    chk($sformatf("%s.u%0d.empty", tag, k), e, int'(n == 0));
    chk($sformatf("%s.u%0d.almost_full", tag, k), af, int'(n >= af_c[k]));
    chk($sformatf("%s.u%0d.almost_empty", tag, k), ae, int'(n <= ae_c[k]));
    chk($sformatf("%s.u%0d.overflow", tag, k), ov, int'(m_ovf[k]));
    chk($sformatf("%s.u%0d.underflow", tag, k), un, int'(m_unf[k]));
    if (fwft_c[k]) begin
      chk($sformatf("%s.u%0d.output_valid", tag, k), vld, int'(n != 0));
      if (n != 0) chk($sformatf("%s.u%0d.output_data", tag, k), dout, int'(qhead(k)));
    end else begin
      chk($sformatf("%s.u%0d.output_valid", tag, k), vld, int'(m_vld[k]));
      chk($sformatf("%s.u%0d.output_data", tag, k), dout, int'(m_dout[k]));
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < 3; j++) check_one(tag, j);
  endtask

  // One clock cycle with inputs on instance k, the others idle.
  task automatic step(input string tag, input int k, input bit clr, input bit wr, input bit rd, input logic [7:0] d);
    set_inputs(k, clr, wr, rd, d);
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (j == k) model_one(j, clr, wr, rd, d);
      else        model_one(j, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    #1;
    set_inputs(-1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_all(tag);
  endtask

  initial begin
    int cnt, f, e, af, ae, ov, un, vld, dout;
    bit wr, rd, clr;
    reset_n = 1'b1;
    set_inputs(-1, 1'b0, 1'b0, 1'b0, 8'h00);
    set_thresh();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(posedge clk); @(posedge clk);
    #2 reset_n = 1'b1;
    check_all("reset_rel");

    // 1: fill depth-16, then reject a 17th write
    for (int i = 1; i <= 16; i++) step("t1.fill", 0, 1'b0, 1'b1, 1'b0, 8'(i));
    step("t1.over", 0, 1'b0, 1'b1, 1'b0, 8'hEE);
    sample(0, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t1.count16", cnt, 16);
    chk("t1.ovf_set", ov, 1);

    // 2: drain in order, then underflow with held data
    for (int i = 1; i <= 16; i++) begin
      step("t2.drain", 0, 1'b0, 1'b0, 1'b1, 8'h00);
      sample(0, cnt, f, e, af, ae, ov, un, vld, dout);
      chk("t2.data_order", dout, i);
    end
    step("t2.under", 0, 1'b0, 1'b0, 1'b1, 8'h00);
    sample(0, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t2.unf_set", un, 1);
    chk("t2.dout_held", dout, 16);

    // 3: depth-5 wrap
    for (int i = 0; i < 3; i++) step("t3.w3", 1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) step("t3.r3", 1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step("t3.w4", 1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) begin
      step("t3.r4", 1, 1'b0, 1'b0, 1'b1, 8'h00);
      sample(1, cnt, f, e, af, ae, ov, un, vld, dout);
      chk("t3.wrap_data", dout, 8'h40 + i);
    end

    // 4: simultaneous read/write on full FIFO
    step("t4.clr", 0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 16; i++) step("t4.fill", 0, 1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 4; i++) step("t4.rw", 0, 1'b0, 1'b1, 1'b1, 8'(8'hA0 + i));
    sample(0, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t4.count16", cnt, 16);
    chk("t4.no_ovf", ov, 0);
    for (int i = 0; i < 16; i++) step("t4.drain", 0, 1'b0, 1'b0, 1'b1, 8'h00);

    // 5: FWFT fall-through
    step("t5.wr", 2, 1'b0, 1'b1, 1'b0, 8'h5A);
    sample(2, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t5.vld", vld, 1);
    chk("t5.data", dout, 8'h5A);
    step("t5.rd", 2, 1'b0, 1'b0, 1'b1, 8'h00);
    sample(2, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t5.empty", e, 1);

    // 6a: clear dominates write/read and clears error flags
    for (int i = 0; i < 6; i++) step("t6.w6", 0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    step("t6.clr", 0, 1'b1, 1'b1, 1'b1, 8'hFF);
    sample(0, cnt, f, e, af, ae, ov, un, vld, dout);
    chk("t6.clr_count", cnt, 0);
    chk("t6.clr_unf", un, 0);
    for (int i = 0; i < 6; i++) step("t6.w6ovf", 1, 1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    step("t6.clr1", 1, 1'b1, 1'b1, 1'b1, 8'hFF);

    // Randomised traffic with random thresholds and occasional flush
    for (int k = 0; k < 3; k++) begin
      af_c[k] = $urandom_range(0, depth_c[k]);
      ae_c[k] = $urandom_range(0, depth_c[k]);
      set_thresh();
      #1 check_all("thresh");
      for (int i = 0; i < 160; i++) begin
        clr = ($urandom_range(0, 31) == 0);
        if (i < 80) begin
          wr = ($urandom_range(0, 3) != 0);
          rd = ($urandom_range(0, 3) == 0);
        end else begin
          wr = ($urandom_range(0, 3) == 0);
          rd = ($urandom_range(0, 3) != 0);
        end
        step("rand", k, clr, wr, rd, 8'($urandom));
      end
    end

    // 6b: asynchronous reset during a write burst
    for (int i = 0; i < 5; i++) step("t6.burst", 0, 1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
    set_inputs(0, 1'b0, 1'b1, 1'b1, 8'hC3);
    @(posedge clk);
    model_one(0, 1'b0, 1'b1, 1'b1, 8'hC3);
    model_one(1, 1'b0, 1'b0, 1'b0, 8'h00);
    model_one(2, 1'b0, 1'b0, 1'b0, 8'h00);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all("t6.async_rst");
    @(posedge clk);
    #1 check_all("t6.rst_held");
    set_inputs(-1, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("t6.post", 2, 1'b0, 1'b1, 1'b0, 8'(8'hD0 + i));
    step("t6.post_rd", 2, 1'b0, 1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock circular FIFO. Adds support for non-power-of-two depth, an optional first-word-fall-through (FWFT) read mode, runtime almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in one clock domain and is the drop-in buffer for new datapaths.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer, need not be a power of two)
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)
CNT_W, $clog2(DEPTH+1), occupancy count width (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush; discards contents and clears error flags
wr_en  input  1  write request
input_data  input  WIDTH  write data
rd_en  input  1  read request (FWFT: pop/acknowledge of the presented word)
output_data  output  WIDTH  read data
output_valid  output  1  output_data holds a valid word (meaning per mode, see below)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
af_thresh  input  CNT_W  almost-full threshold (quasi-static)
ae_thresh  input  CNT_W  almost-empty threshold (quasi-static)
count  output  CNT_W  current number of stored entries
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, output_data=0, output_valid=0, overflow=0, underflow=0. Therefore full=0, empty=1, almost_empty=(0<=ae_thresh)=1, almost_full=(af_thresh==0). Memory contents are not reset.
- full, empty, almost_full and almost_empty are combinational compares of the registered count. No other combinational path feeds them.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_en). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- A write and a read on an empty FIFO: the write is accepted, the read is rejected, and underflow is set.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur. Count never exceeds DEPTH and never goes below 0.
- Pointers advance by 1 on their accept. The value DEPTH-1 wraps to 0 by explicit compare, not by modulo-2^PTR_W.
- overflow is set when wr_en && full && !rd_en.
- underflow is set when rd_en && empty.
- Both error flags hold until clear or reset.
- Standard mode (FWFT=0):
  - On rd_acc, output_data <= mem[rd_ptr] at the next edge (1-cycle latency).
  - output_valid pulses high for exactly the cycle after each rd_acc.
  - output_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - output_data = mem[rd_ptr] combinationally; output_valid = !empty.
  - rd_en consumes the presented word. The next word, if any, appears in the same cycle the pointer advances.
  - A written word becomes visible on output_data in the cycle after the write edge (0 extra latency beyond storage).
- clear:
  - Takes effect at the edge and dominates wr_en/rd_en in the same cycle (no write stored, no read performed).
  - Sets pointers and count to 0, output_valid to 0, and overflow/underflow to 0.
  - In standard mode output_data keeps its value.
- Reset mid-operation: asynchronous return to the reset state within the same cycle. No partial write is committed after reset_n falls.
- Thresholds are sampled continuously. Changing them changes the flags combinationally; callers hold them static during traffic.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 helper (for tools lacking $clog2)
  - the mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1
  - the err-flag bit indices for future status-register packing
- One sub-module, fifo_ram: DEPTH x WIDTH storage, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata). It isolates storage so that a vendor RAM macro can be swapped in later.
- Pointer, count, flag and mode logic live in sync_fifo_flex.

Test Plan:
1. DEPTH=16, FWFT=0. Write 0x01..0x10 on 16 consecutive cycles -> full=1, count=16, almost_full=1 (af_thresh=14). A 17th write with rd_en=0 -> rejected, overflow=1, count stays 16.
2. Continuing from test 1, read 16 times -> output_data is 0x01..0x10, each appearing one cycle after its rd_en, with output_valid pulsing each time. Then empty=1. A 17th read -> underflow=1, output_data stays 0x10.
3. DEPTH=5 (non-power-of-two), FWFT=0. Write 3, read 3, write 4, read 4 -> data order is preserved across the wrap at pointer 4->0, and count is never greater than 5.
4. Full FIFO (DEPTH=16) with wr_en=1 and rd_en=1 together for 4 cycles, writing 0xA0..0xA3 -> count stays 16, overflow stays 0. Draining afterwards yields old entries 5..16, then 0xA0..0xA3.
5. FWFT=1. Write 0x5A into an empty FIFO -> next cycle output_valid=1 and output_data=0x5A with no rd_en. Assert rd_en one cycle -> empty=1 and output_valid=0.
6. Write 6 words, assert clear together with wr_en and rd_en -> next cycle count=0, empty=1, overflow=0, underflow=0. Separately, drop reset_n mid-burst -> all outputs take reset values immediately.
